// File: rtl/ccu_pkg.sv
// Shared definitions for the context sequencer: opcodes, context-word field
// layout helpers and the sequencer FSM encoding.
package ccu_pkg;

  localparam logic [2:0] OP_NEXT      = 3'd0;
  localparam logic [2:0] OP_JUMP      = 3'd1;
  localparam logic [2:0] OP_BRANCH    = 3'd2;
  localparam logic [2:0] OP_CALL      = 3'd3;
  localparam logic [2:0] OP_RET       = 3'd4;
  localparam logic [2:0] OP_LOOP_PUSH = 3'd5;
  localparam logic [2:0] OP_LOOP_END  = 3'd6;
  localparam logic [2:0] OP_HALT      = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ccu_state_e;

  function automatic int csel_width(input int cond_w);
    return (cond_w > 1) ? $clog2(cond_w) : 1;
  endfunction

  function automatic int ctx_width(input int aw, input int csel_w);
    return aw + csel_w + 5;
  endfunction

  // Word layout, LSB first: addr | csel | inv | rel | op
  function automatic int off_csel(input int aw);
    return aw;
  endfunction

  function automatic int off_inv(input int aw, input int csel_w);
    return aw + csel_w;
  endfunction

  function automatic int off_rel(input int aw, input int csel_w);
    return aw + csel_w + 1;
  endfunction

  function automatic int off_op(input int aw, input int csel_w);
    return aw + csel_w + 2;
  endfunction

endpackage

// File: rtl/ccu_lifo.sv
// Small LIFO with push, pop and in-place top modification; used for both the
// return-address stack and the loop-count stack.
module ccu_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             mod,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] mod_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0]    ptr_q;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign full  = (ptr_q == PW'(DEPTH));
  assign empty = (ptr_q == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PW'(i + 1)) top = stack_q[i];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I || clr) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end

  // Entry storage is plain data and carries no reset.
  always_ff @(posedge CLK_I) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && ptr_q == PW'(i)) begin
        stack_q[i] <= push_data;
      end else if (mod && ptr_q == PW'(i + 1)) begin
        stack_q[i] <= mod_data;
      end
    end
  end

endmodule

// File: rtl/context_sequencer.sv
// Context counter generator for the CGRA: branch selector, call/return stack
// and nested zero-overhead loops driving every PE context memory in lock-step.
module context_sequencer
  import ccu_pkg::*;
#(
  parameter int CONTEXT_ADDR_WIDTH    = 8,
  parameter int CONTEXT_MEMORY_LENGTH = 256,
  parameter int COND_WIDTH            = 4,
  parameter int CALL_DEPTH            = 4,
  parameter int LOOP_DEPTH            = 2
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic                          EN_I,
  input  logic [COND_WIDTH-1:0]         CBOX_I,
  input  logic [ctx_width(CONTEXT_ADDR_WIDTH, csel_width(COND_WIDTH))-1:0] CONTEXT_DATA_I,
  input  logic                          CONTEXT_WR_EN_I,
  input  logic [CONTEXT_ADDR_WIDTH-1:0] CONTEXT_WR_ADDR_I,
  input  logic [CONTEXT_ADDR_WIDTH-1:0] ADDR_I,
  input  logic                          LOAD_EN_I,
  output logic [CONTEXT_ADDR_WIDTH-1:0] CCNT_O,
  output logic                          RUNNING_O,
  output logic                          DONE_O,
  output logic                          ERR_O
);

  localparam int AW     = CONTEXT_ADDR_WIDTH;
  localparam int CSEL_W = csel_width(COND_WIDTH);
  localparam int W      = ctx_width(AW, CSEL_W);
  localparam int MW     = $clog2(CONTEXT_MEMORY_LENGTH);
  localparam logic [AW:0] MEM_LEN = (AW + 1)'(CONTEXT_MEMORY_LENGTH);

  ccu_state_e state_q, state_d;

  logic [AW-1:0] pc_q;
  logic [W-1:0]  word_q;
  logic [W-1:0]  mem [CONTEXT_MEMORY_LENGTH];
  logic          err_q;

  logic [AW-1:0]     w_addr;
  logic [CSEL_W-1:0] w_csel;
  logic              w_inv, w_rel;
  logic [2:0]        w_op;

  logic [AW-1:0] pc_inc, tgt, cand, ccnt;
  logic          cbit, cond, stk_fault, range_fault, fault;
  logic          commit, clr, exec, set_err, done;
  logic          rd_ok, wr_ok;

  logic [AW-1:0] call_top, loop_top;
  logic          call_full, call_empty, loop_full, loop_empty;
  logic          call_push, call_pop, loop_push, loop_end, loop_pop, loop_dec;

  assign w_addr = word_q[AW-1:0];
  assign w_csel = word_q[off_csel(AW) +: CSEL_W];
  assign w_inv  = word_q[off_inv(AW, CSEL_W)];
  assign w_rel  = word_q[off_rel(AW, CSEL_W)];
  assign w_op   = word_q[off_op(AW, CSEL_W) +: 3];

  assign pc_inc = pc_q + AW'(1);
  assign tgt    = w_rel ? (pc_q + w_addr) : w_addr;

  // Selects beyond the implemented C-box bits read as zero before inversion.
  always_comb begin
    cbit = 1'b0;
    for (int i = 0; i < COND_WIDTH; i++) begin
      if (w_csel == CSEL_W'(i)) cbit = CBOX_I[i];
    end
  end

  assign cond = cbit ^ w_inv;

  always_comb begin
    cand      = pc_inc;
    stk_fault = 1'b0;
    case (w_op)
      OP_NEXT:      cand = pc_inc;
      OP_JUMP:      cand = tgt;
      OP_BRANCH:    cand = cond ? tgt : pc_inc;
      OP_CALL: begin
        cand      = tgt;
        stk_fault = call_full;
      end
      OP_RET: begin
        cand      = call_top;
        stk_fault = call_empty;
      end
      OP_LOOP_PUSH: stk_fault = loop_full;
      OP_LOOP_END: begin
        cand      = (loop_top != '0) ? tgt : pc_inc;
        stk_fault = loop_empty;
      end
      OP_HALT:      cand = pc_q;
      default:      cand = pc_inc;
    endcase
  end

  assign range_fault = ({1'b0, cand} >= MEM_LEN);
  assign fault       = stk_fault | range_fault;

  // Load outranks the opcode; a faulting word holds the counter on itself.
  always_comb begin
    ccnt    = pc_q;
    state_d = state_q;
    commit  = 1'b0;
    clr     = 1'b0;
    exec    = 1'b0;
    set_err = 1'b0;
    done    = 1'b0;
    if (LOAD_EN_I) begin
      ccnt = ADDR_I;
      if (EN_I) begin
        commit  = 1'b1;
        clr     = 1'b1;
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      ccnt = fault ? pc_q : cand;
      if (EN_I) begin
        commit = 1'b1;
        if (fault) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          exec = 1'b1;
          if (w_op == OP_HALT) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  assign call_push = exec && (w_op == OP_CALL);
  assign call_pop  = exec && (w_op == OP_RET);
  assign loop_push = exec && (w_op == OP_LOOP_PUSH);
  assign loop_end  = exec && (w_op == OP_LOOP_END);
  assign loop_dec  = loop_end && (loop_top != '0);
  assign loop_pop  = loop_end && (loop_top == '0);

  ccu_lifo #(.WIDTH(AW), .DEPTH(CALL_DEPTH)) u_call_stack (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .clr       (clr),
    .push      (call_push),
    .pop       (call_pop),
    .mod       (1'b0),
    .push_data (pc_inc),
    .mod_data  ({AW{1'b0}}),
    .top       (call_top),
    .full      (call_full),
    .empty     (call_empty)
  );

  ccu_lifo #(.WIDTH(AW), .DEPTH(LOOP_DEPTH)) u_loop_stack (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .clr       (clr),
    .push      (loop_push),
    .pop       (loop_pop),
    .mod       (loop_dec),
    .push_data (w_addr),
    .mod_data  (loop_top - AW'(1)),
    .top       (loop_top),
    .full      (loop_full),
    .empty     (loop_empty)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) pc_q <= ccnt;
      if (clr) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_ok = ({1'b0, ccnt} < MEM_LEN);
  assign wr_ok = ({1'b0, CONTEXT_WR_ADDR_I} < MEM_LEN);

  // Same-address write and read in one cycle returns the old word.
  always_ff @(posedge CLK_I) begin
    if (CONTEXT_WR_EN_I && wr_ok) mem[CONTEXT_WR_ADDR_I[MW-1:0]] <= CONTEXT_DATA_I;
    if (commit) word_q <= rd_ok ? mem[ccnt[MW-1:0]] : '0;
  end

  assign CCNT_O    = ccnt;
  assign RUNNING_O = (state_q == ST_RUN);
  assign DONE_O    = done;
  assign ERR_O     = err_q;

endmodule

// File: tb/tb_context_sequencer.sv
// Bench for context_sequencer: vector tables, hand-written corner sequences and
// a randomized run, all checked against a queue-based program-execution model.
module tb_context_sequencer;

  localparam int LEN = 256;

  logic CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  logic        rst, en, ld, wr_en;
  logic [7:0]  addr, wr_addr;
  logic [3:0]  cbox;
  logic [14:0] wr_data;

  logic [7:0] ccnt0, ccnt1;
  logic       run0, done0, err0, run1, done1, err1;

  context_sequencer #(
    .CONTEXT_ADDR_WIDTH(8), .CONTEXT_MEMORY_LENGTH(256), .COND_WIDTH(4),
    .CALL_DEPTH(4), .LOOP_DEPTH(2)
  ) u_dut (
    .CLK_I(CLK_I), .RST_I(rst), .EN_I(en), .CBOX_I(cbox),
    .CONTEXT_DATA_I(wr_data), .CONTEXT_WR_EN_I(wr_en), .CONTEXT_WR_ADDR_I(wr_addr),
    .ADDR_I(addr), .LOAD_EN_I(ld), .CCNT_O(ccnt0), .RUNNING_O(run0),
    .DONE_O(done0), .ERR_O(err0)
  );

  context_sequencer #(
    .CONTEXT_ADDR_WIDTH(8), .CONTEXT_MEMORY_LENGTH(256), .COND_WIDTH(4),
    .CALL_DEPTH(1), .LOOP_DEPTH(2)
  ) u_dut1 (
    .CLK_I(CLK_I), .RST_I(rst), .EN_I(en), .CBOX_I(cbox),
    .CONTEXT_DATA_I(wr_data), .CONTEXT_WR_EN_I(wr_en), .CONTEXT_WR_ADDR_I(wr_addr),
    .ADDR_I(addr), .LOAD_EN_I(ld), .CCNT_O(ccnt1), .RUNNING_O(run1),
    .DONE_O(done1), .ERR_O(err1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: program state as plain integers and queues
  int  m_mem [LEN];
  bit  m_run, m_err;
  int  m_pc, m_word;
  int  m_cs[$];
  int  m_ls[$];

  integer a_ccnt, a_done, a_run, a_err, a1_ccnt;
  integer e_ccnt, e_done, e_run, e_err;

  typedef struct {
    bit en;
    bit ld;
    int addr;
    int cbox;
    int ccnt;
    int done;
    int run;
    int err;
  } vec_t;
  vec_t vq[$];

  function automatic int mk(input int op, input int rel, input int inv, input int cs, input int a);
    return (op << 12) | (rel << 11) | (inv << 10) | (cs << 8) | (a & 255);
  endfunction

  task automatic chk(input string nm, input integer act, input integer exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 0; m_pc = 0;
    m_cs.delete(); m_ls.delete();
  endtask

  task automatic model_step();
    int w, op, rel, inv, cs, a, tgt, nxt, c;
    bit flt, halt;
    e_run  = m_run;
    e_err  = m_err;
    e_done = 0;
    if (!m_run || ld) begin
      e_ccnt = ld ? addr : m_pc;
      if (ld && en) begin
        m_cs.delete(); m_ls.delete();
        m_err = 0; m_run = 1; m_pc = addr; m_word = m_mem[addr];
      end
    end else begin
      w   = m_word;
      op  = (w >> 12) & 7; rel = (w >> 11) & 1; inv = (w >> 10) & 1;
      cs  = (w >> 8) & 3;  a   = w & 255;
      tgt = rel ? (m_pc + a) % 256 : a;
      c   = cbox[cs] ^ inv;
      flt = 0; halt = 0;
      nxt = (m_pc + 1) % 256;
      case (op)
        1: nxt = tgt;
        2: if (c != 0) nxt = tgt;
        3: if (m_cs.size() >= 4) flt = 1; else nxt = tgt;
        4: if (m_cs.size() == 0) flt = 1; else nxt = m_cs[m_cs.size()-1];
        5: if (m_ls.size() >= 2) flt = 1;
        6: if (m_ls.size() == 0) flt = 1; else if (m_ls[m_ls.size()-1] > 0) nxt = tgt;
        7: begin nxt = m_pc; halt = 1; end
        default: ;
      endcase
      if (nxt >= LEN) flt = 1;
      e_ccnt = flt ? m_pc : nxt;
      e_done = (en && halt && !flt) ? 1 : 0;
      if (en) begin
        if (flt) begin
          m_err = 1; m_run = 0;
        end else begin
          case (op)
            3: m_cs.push_back((m_pc + 1) % 256);
            4: void'(m_cs.pop_back());
            5: m_ls.push_back(a);
            6: if (m_ls[m_ls.size()-1] > 0) m_ls[m_ls.size()-1] = m_ls[m_ls.size()-1] - 1;
               else void'(m_ls.pop_back());
            7: m_run = 0;
            default: ;
          endcase
        end
        m_pc = e_ccnt; m_word = m_mem[e_ccnt];
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    #1;
    a_ccnt = ccnt0; a_done = done0; a_run = run0; a_err = err0; a1_ccnt = ccnt1;
    if (rst) begin
      model_reset();
    end else begin
      model_step();
      chk("mdl_ccnt", a_ccnt, e_ccnt);
      chk("mdl_done", a_done, e_done);
      chk("mdl_running", a_run, e_run);
      chk("mdl_err", a_err, e_err);
    end
    @(posedge CLK_I);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    en = 0; ld = 0; wr_en = 1; wr_addr = a[7:0]; wr_data = d[14:0];
    tick();
    wr_en = 0;
  endtask

  task automatic add(input bit e, input bit l, input int ad, input int cb,
                     input int cc, input int dn, input int rn, input int er);
    vq.push_back('{e, l, ad, cb, cc, dn, rn, er});
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      en = vq[i].en; ld = vq[i].ld; addr = vq[i].addr[7:0]; cbox = vq[i].cbox[3:0];
      wr_en = 0;
      tick();
      chk($sformatf("%s[%0d].ccnt", tag, i), a_ccnt, vq[i].ccnt);
      chk($sformatf("%s[%0d].done", tag, i), a_done, vq[i].done);
      chk($sformatf("%s[%0d].running", tag, i), a_run, vq[i].run);
      chk($sformatf("%s[%0d].err", tag, i), a_err, vq[i].err);
    end
    vq.delete();
    en = 0; ld = 0;
  endtask

  // Nested call program; the depth-1 instance must fault on the inner CALL.
  task automatic call_seq(input string tag);
    int seq [8] = '{10, 20, 21, 30, 22, 23, 11, 11};
    for (int k = 0; k < 8; k++) begin
      en = 1; ld = (k == 0); addr = 8'd10; cbox = 4'd0;
      tick();
      chk($sformatf("%s.ccnt%0d", tag, k), a_ccnt, seq[k]);
      if (k == 3) begin
        chk($sformatf("%s.d1_ccnt", tag), a1_ccnt, 21);
        chk($sformatf("%s.d1_err", tag), err1, 1);
        chk($sformatf("%s.d1_running", tag), run1, 0);
      end
    end
    chk($sformatf("%s.done", tag), a_done, 1);
    chk($sformatf("%s.err", tag), err0, 0);
    en = 0; ld = 0;
  endtask

  initial begin
    rst = 1; en = 0; ld = 0; addr = '0; cbox = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < LEN; i++) m_mem[i] = 0;
    m_word = 0;
    model_reset();
    @(posedge CLK_I); #1;
    tick();
    rst = 0;

    tick();
    chk("reset_ccnt", a_ccnt, 0);
    chk("reset_running", a_run, 0);
    chk("reset_done", a_done, 0);
    chk("reset_err", a_err, 0);

    for (int i = 0; i < LEN; i++) wr(i, mk(7, 0, 0, 0, 0));

    // Linear run
    wr(0, mk(0,0,0,0,0)); wr(1, mk(0,0,0,0,0)); wr(2, mk(0,0,0,0,0)); wr(3, mk(7,0,0,0,0));
    add(1,1,0,0, 0,0,0,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 2,0,1,0);
    add(1,0,0,0, 3,0,1,0); add(1,0,0,0, 3,1,1,0); add(0,0,0,0, 3,0,0,0);
    run_vecs("linear");

    // Branch, both polarities
    wr(5, mk(2, 1, 0, 2, 4));
    add(1,1,5,0, 5,0,0,0); add(1,0,0,4, 9,0,1,0); add(1,0,0,0, 9,1,1,0);
    add(1,1,5,0, 5,0,0,0); add(1,0,0,0, 6,0,1,0); add(1,0,0,0, 6,1,1,0);
    run_vecs("branch");
    wr(5, mk(2, 1, 1, 2, 4));
    add(1,1,5,0, 5,0,0,0); add(1,0,0,4, 6,0,1,0); add(1,0,0,0, 6,1,1,0);
    add(1,1,5,0, 5,0,0,0); add(1,0,0,0, 9,0,1,0); add(1,0,0,0, 9,1,1,0);
    add(0,0,0,0, 9,0,0,0);
    run_vecs("branch_inv");

    // Nested call / return
    wr(10, mk(3,0,0,0,20)); wr(20, mk(0,0,0,0,0)); wr(21, mk(3,0,0,0,30));
    wr(30, mk(4,0,0,0,0));  wr(22, mk(0,0,0,0,0)); wr(23, mk(4,0,0,0,0));
    call_seq("call");

    // Loop with a three-cycle stall in the middle
    wr(0, mk(5,0,0,0,2)); wr(1, mk(0,0,0,0,0)); wr(2, mk(6,0,0,0,1)); wr(3, mk(7,0,0,0,0));
    add(1,1,0,0, 0,0,0,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 2,0,1,0);
    add(1,0,0,0, 1,0,1,0); add(0,0,0,0, 2,0,1,0); add(0,0,0,0, 2,0,1,0);
    add(0,0,0,0, 2,0,1,0); add(1,0,0,0, 2,0,1,0); add(1,0,0,0, 1,0,1,0);
    add(1,0,0,0, 2,0,1,0); add(1,0,0,0, 3,0,1,0); add(1,0,0,0, 3,1,1,0);
    add(0,0,0,0, 3,0,0,0);
    run_vecs("loop_stall");

    // LOOP_END with empty loop stack, then a load clears the error
    wr(40, mk(6,0,0,0,0));
    add(1,1,40,0, 40,0,0,0); add(1,0,0,0, 40,0,1,0); add(0,0,0,0, 40,0,0,1);
    add(1,1,0,0, 0,0,0,1);   add(1,0,0,0, 1,0,1,0);  add(1,0,0,0, 2,0,1,0);
    add(1,0,0,0, 1,0,1,0);   add(1,0,0,0, 2,0,1,0);  add(1,0,0,0, 1,0,1,0);
    add(1,0,0,0, 2,0,1,0);   add(1,0,0,0, 3,0,1,0);  add(1,0,0,0, 3,1,1,0);
    add(0,0,0,0, 3,0,0,0);
    run_vecs("loop_fault");

    // Reload mid-call: return stack must be emptied, so the RET faults
    add(1,1,10,0, 10,0,0,0); add(1,0,0,0, 20,0,1,0); add(1,1,23,0, 23,0,1,0);
    add(1,0,0,0, 23,0,1,0);  add(0,0,0,0, 23,0,0,1);
    run_vecs("reload");

    // Reset in the middle of a call
    add(1,1,10,0, 10,0,0,1); add(1,0,0,0, 20,0,1,0); add(1,0,0,0, 21,0,1,0);
    run_vecs("pre_reset");
    rst = 1; en = 1; ld = 0;
    tick();
    rst = 0; en = 0;
    tick();
    chk("midreset_ccnt", a_ccnt, 0);
    chk("midreset_running", a_run, 0);
    chk("midreset_done", a_done, 0);
    chk("midreset_err", a_err, 0);
    call_seq("call_after_reset");

    // Randomized programs and stimulus against the model
    for (int i = 0; i < LEN; i++) wr(i, int'($urandom_range(0, 32767)));
    for (int n = 0; n < 3000; n++) begin
      en      = ($urandom % 4) != 0;
      ld      = ($urandom % 12) == 0;
      addr    = 8'($urandom % 256);
      cbox    = 4'($urandom % 16);
      wr_en   = ($urandom % 8) == 0;
      wr_addr = 8'($urandom % 256);
      wr_data = 15'($urandom % 32768);
      tick();
    end
    en = 0; ld = 0; wr_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
